exp_accel_avs: RTL and testbench
================================

Name: exp_accel_avs

Overview:
- Avalon-MM slave (responder) modular-exponentiation engine inside exponent_accelerator_system.
- The system's processor master writes base/exponent/modulus, starts the engine, polls status, and reads the result.
- Core is right-to-left square-and-multiply over a bit-serial interleaved modular multiplier (WIDTH cycles per modmul).

Parameters:
- WIDTH, 32, operand/result width in bits (8..32); all registers zero-extended to 32 on readdata.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  4  word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- readdata  out  32  read data, registered
- waitrequest  out  1  slave stall

Behaviour:
- Register map (word address):
  - 0 W = START (any value); 0 R = STATUS {bit0 busy, bit1 done, bit2 err_mod0, bit3 err_busy}.
  - 1 BASE rw, 2 EXP rw, 3 MOD rw, 4 RESULT ro.
  - 5 IEN (optional feature only); otherwise 5-15 read 0, writes ignored.
- Reset: all registers 0, readdata 0, waitrequest 0, state IDLE.
- Writes: zero wait states (waitrequest stays 0); take effect at the clock edge.
  - While busy: writes to 0-3 are ignored and set err_busy (sticky).
- Reads:
  - Cycle 1 of every read: waitrequest=1, readdata registered.
  - Next cycle: waitrequest=0, readdata valid.
  - Read of RESULT while busy: waitrequest held 1 until the cycle after busy falls, then returns the final result.
  - read and write asserted together: write performed, read ignored, waitrequest 0.
- Accepted START (IDLE):
  - Clears done, err_mod0 and err_busy.
  - If MOD==0: err_mod0=1, done=1, RESULT=0, busy never asserts.
  - Otherwise, next cycle: busy=1; latch m=MOD, e=EXP; acc=(m==1)?0:1.
- FSM: IDLE -> REDUCE -> CHECK -> {MUL -> CHECK' | SQR} ... -> IDLE.
  - REDUCE: WIDTH cycles, b = BASE mod m.
  - CHECK (1 cycle):
    - e==0: RESULT=acc, busy=0, done=1, -> IDLE.
    - e[0]==1: -> MUL.
    - e[0]==0: e>>=1, -> SQR.
  - MUL: WIDTH cycles, acc=acc*b mod m; then e>>=1; if e!=0 -> SQR, else -> CHECK.
  - SQR: WIDTH cycles, b=b*b mod m; -> CHECK.
- Modmul step, MSB first over multiplier x, r starting at 0, WIDTH+1-bit r:
  - r=2r; if r>=m, r-=m.
  - If x[i]: r+=y; if r>=m, r-=m.
  - Operands are always < m, so no overflow occurs.
- Busy duration in cycles, with L = bit length of EXP and P = popcount(EXP):
  - WIDTH*(1+P+max(L-1,0)) + (L+1).
  - Busy rises the cycle after the START write.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro EXP_ACCEL_IRQ_EN.
- Defined:
  - Adds output irq (1 bit), plus register 5 IEN (bit0 rw, reset 0).
  - irq = done & IEN[0], registered.
  - Cleared by an accepted START or by writing IEN=0.
  - err_mod0 completion also raises irq.
- Undefined:
  - No irq port.
  - Address 5 reads 0 and ignores writes.

Test Plan:
- WIDTH=32, BASE=4, EXP=13, MOD=497, START -> busy exactly 229 cycles, STATUS=0x2, RESULT=445.
- BASE=7, EXP=0, MOD=13 -> busy 33 cycles, RESULT=1; repeat with MOD=1 -> RESULT=0.
- MOD=0, START -> busy never 1, STATUS=0x6, RESULT=0.
- BASE=0xFFFFFFFF, EXP=0xFFFFFFFF, MOD=0xFFFFFFFB:
  - Read RESULT right after START -> waitrequest held until done; readdata equals the software model value.
  - Write EXP mid-run -> ignored, err_bit3=1.
- Reset asserted mid-SQR -> all registers 0, waitrequest 0; new run BASE=3, EXP=5, MOD=7 -> RESULT=5.
- With EXP_ACCEL_IRQ_EN, IEN=1, run BASE=2, EXP=10, MOD=1000 -> irq rises with done, RESULT=24; new START -> irq 0.

Source files
------------

// File: rtl/exp_accel_avs.sv
// Avalon-MM modular exponentiation engine: right-to-left square-and-multiply over a bit-serial
// interleaved modular multiplier. Define EXP_ACCEL_IRQ_EN to add the IEN register and irq output.
module exp_accel_avs #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
`ifdef EXP_ACCEL_IRQ_EN
  output logic        irq,
`endif
  output logic        waitrequest
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_CHECK, S_MUL, S_SQR} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] base_q, exp_q, mod_q, res_q, res_d;
  logic [WIDTH-1:0] m_q, e_q, acc_q, b_q, x_q, y_q, r_q, r_step, ld_x, ld_y;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   m_ext, t_dbl, t_red, t_add;
  logic [31:0]      readdata_q, rmux;
  logic done_q, done_d, err0_q, err0_d, errb_q, errb_d, rd_ack_q;
  logic busy, in_mm, mm_last, start_acc, start_go, ld_mm, e_shift, fin;
  logic rd_req, rd_stall, rd_fire;

  assign busy      = (state_q != S_IDLE);
  assign in_mm     = (state_q == S_REDUCE) || (state_q == S_MUL) || (state_q == S_SQR);
  assign mm_last   = in_mm && (cnt_q == CNT_LAST);
  assign start_acc = write && (address == 4'd0) && !busy;
  assign start_go  = start_acc && (mod_q != '0);

  // One interleaved modmul step: r = 2r (+y) mod m; operands below m keep it within WIDTH+1 bits.
  assign m_ext = {1'b0, m_q};
  assign t_dbl = {r_q, 1'b0};
  assign t_red = (t_dbl >= m_ext) ? t_dbl - m_ext : t_dbl;
  assign t_add = t_red + {1'b0, y_q};
  always_comb begin
    r_step = WIDTH'(t_red);
    if (x_q[WIDTH-1]) r_step = (t_add >= m_ext) ? WIDTH'(t_add - m_ext) : WIDTH'(t_add);
  end

  always_comb begin
    state_d = state_q;
    ld_mm   = 1'b0;
    ld_x    = '0;
    ld_y    = '0;
    e_shift = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE:   if (start_go) begin
        state_d = S_REDUCE; ld_mm = 1'b1; ld_x = base_q; ld_y = WIDTH'(1);
      end
      S_REDUCE: if (mm_last) state_d = S_CHECK;
      S_CHECK: begin
        if (e_q == '0) begin
          state_d = S_IDLE; fin = 1'b1;
        end else if (e_q[0]) begin
          state_d = S_MUL; ld_mm = 1'b1; ld_x = acc_q; ld_y = b_q;
        end else begin
          state_d = S_SQR; e_shift = 1'b1; ld_mm = 1'b1; ld_x = b_q; ld_y = b_q;
        end
      end
      S_MUL: if (mm_last) begin
        e_shift = 1'b1;
        if (e_q[WIDTH-1:1] != '0) begin
          state_d = S_SQR; ld_mm = 1'b1; ld_x = b_q; ld_y = b_q;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_SQR: if (mm_last) state_d = S_CHECK;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d = done_q;
    err0_d = err0_q;
    errb_d = errb_q;
    res_d  = res_q;
    if (write && busy && (address <= 4'd3)) errb_d = 1'b1;
    if (start_acc) begin
      done_d = (mod_q == '0);
      err0_d = (mod_q == '0);
      errb_d = 1'b0;
      if (mod_q == '0) res_d = '0;
    end
    if (fin) begin
      done_d = 1'b1;
      res_d  = acc_q;
    end
  end

  // A read costs one stall cycle; RESULT reads additionally stall until the engine is idle.
  assign rd_req      = read && !write;
  assign rd_stall    = (address == 4'd4) && busy;
  assign rd_fire     = rd_req && !rd_ack_q && !rd_stall;
  assign waitrequest = rd_req && !rd_ack_q;
  assign readdata    = readdata_q;

`ifdef EXP_ACCEL_IRQ_EN
  logic ien_q, ien_d, irq_q;
  assign ien_d = (write && (address == 4'd5)) ? writedata[0] : ien_q;
  assign irq   = irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ien_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      irq_q <= done_d && ien_d;
    end
  end
`endif

  always_comb begin
    rmux = '0;
    case (address)
      4'd0: rmux = {28'd0, errb_q, err0_q, done_q, busy};
      4'd1: rmux = 32'(base_q);
      4'd2: rmux = 32'(exp_q);
      4'd3: rmux = 32'(mod_q);
      4'd4: rmux = 32'(res_q);
`ifdef EXP_ACCEL_IRQ_EN
      4'd5: rmux = {31'd0, ien_q};
`endif
      default: rmux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0; exp_q <= '0; mod_q <= '0; res_q <= '0;
      done_q <= 1'b0; err0_q <= 1'b0; errb_q <= 1'b0;
      readdata_q <= '0; rd_ack_q <= 1'b0;
    end else begin
      if (write && !busy) begin
        case (address)
          4'd1: base_q <= writedata[WIDTH-1:0];
          4'd2: exp_q  <= writedata[WIDTH-1:0];
          4'd3: mod_q  <= writedata[WIDTH-1:0];
          default: ;
        endcase
      end
      done_q   <= done_d;
      err0_q   <= err0_d;
      errb_q   <= errb_d;
      res_q    <= res_d;
      rd_ack_q <= rd_fire;
      if (rd_fire) readdata_q <= rmux;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q <= '0; e_q <= '0; acc_q <= '0; b_q <= '0;
      x_q <= '0; y_q <= '0; r_q <= '0; cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        m_q   <= mod_q;
        e_q   <= exp_q;
        acc_q <= (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
      end
      if (e_shift) e_q <= e_q >> 1;
      if (ld_mm) begin
        x_q <= ld_x; y_q <= ld_y; r_q <= '0; cnt_q <= '0;
      end else if (in_mm) begin
        r_q   <= r_step;
        x_q   <= x_q << 1;
        cnt_q <= cnt_q + CW'(1);
      end
      if (mm_last) begin
        if (state_q == S_MUL) acc_q <= r_step;
        else                  b_q   <= r_step;
      end
    end
  end
endmodule

// File: tb/tb_exp_accel_avs.sv
// Self-checking bench for exp_accel_avs: plain-arithmetic modexp/latency model, directed and random runs.
module tb_exp_accel_avs;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest;
`ifdef EXP_ACCEL_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exp_accel_avs #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata),
`ifdef EXP_ACCEL_IRQ_EN
    .irq(irq),
`endif
    .waitrequest(waitrequest)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: b^e mod m by plain 64-bit arithmetic.
  function automatic logic [31:0] m_pow(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    longint unsigned r, x, mm;
    if (m == 0) return 32'd0;
    mm = 64'(m);
    r  = 64'd1 % mm;
    x  = 64'(b) % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  function automatic int busy_len(input logic [31:0] e, input logic [31:0] m);
    int l, p;
    if (m == 0) return 0;
    l = 0; p = 0;
    for (int i = 0; i < 32; i++) if (e[i]) begin l = i + 1; p++; end
    return WIDTH * (1 + p + ((l > 0) ? l - 1 : 0)) + l + 1;
  endfunction

  // Waitrequest must be low whenever no read is pending or a write is present.
  always @(negedge clk) begin
    #2;
    if (!read || write) chk("waitrequest_idle", 32'(waitrequest), 32'd0);
  end

  // Bus tasks are entered and left at a falling edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    #1 chk("wr_waitrequest", 32'(waitrequest), 32'd0);
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output int n);
    address = a; read = 1'b1; n = 0;
    #1;
    while (waitrequest && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (waitrequest) chk("read_timeout", 32'(waitrequest), 32'd0);
    d = readdata;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic run_raw(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                         output logic [31:0] res, output int busy, output logic [31:0] st);
    int n;
    bus_write(4'd1, b);
    bus_write(4'd2, e);
    bus_write(4'd3, m);
    bus_write(4'd0, 32'd0);
    bus_read(4'd4, res, n);
    busy = n - 1;
    bus_read(4'd0, st, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, st, b, e, m;
    int n, bz;

    repeat (3) @(negedge clk);
    chk("reset_waitrequest", 32'(waitrequest), 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      bus_read(4'(a), d, n);
      chk($sformatf("reset_reg%0d", a), d, 32'd0);
    end
    chk("read_latency", 32'(n), 32'd1);

    run_raw(32'd4, 32'd13, 32'd497, d, bz, st);
    chk("t1_result", d, 32'd445);
    chk("t1_busy", 32'(bz), 32'd229);
    chk("t1_status", st, 32'h2);

    run_raw(32'd7, 32'd0, 32'd13, d, bz, st);
    chk("e0_result", d, 32'd1);
    chk("e0_busy", 32'(bz), 32'd33);
    run_raw(32'd7, 32'd0, 32'd1, d, bz, st);
    chk("m1_result", d, 32'd0);
    chk("m1_busy", 32'(bz), 32'd33);
    chk("m1_status", st, 32'h2);

    run_raw(32'd9, 32'd3, 32'd0, d, bz, st);
    chk("mod0_result", d, 32'd0);
    chk("mod0_busy", 32'(bz), 32'd0);
    chk("mod0_status", st, 32'h6);

    b = 32'hFFFFFFFF; e = 32'hFFFFFFFF; m = 32'hFFFFFFFB;
    run_raw(b, e, m, d, bz, st);
    chk("big_result", d, m_pow(b, e, m));
    chk("big_busy", 32'(bz), 32'(busy_len(e, m)));
    chk("big_status", st, 32'h2);

    bus_write(4'd0, 32'd0);
    bus_write(4'd2, 32'd5);
    bus_read(4'd0, d, n);
    chk("busy_write_status", d, 32'h9);
    bus_read(4'd4, d, n);
    chk("busy_write_result", d, m_pow(b, e, m));
    bus_read(4'd0, d, n);
    chk("busy_write_done", d, 32'hA);
    bus_read(4'd2, d, n);
    chk("busy_write_exp_kept", d, 32'hFFFFFFFF);

    bus_write(4'd4, 32'd123);
    bus_read(4'd4, d, n);
    chk("result_ro", d, m_pow(b, e, m));
    bus_write(4'd9, 32'hDEAD);
    bus_read(4'd9, d, n);
    chk("unmapped_reg", d, 32'd0);
`ifndef EXP_ACCEL_IRQ_EN
    bus_write(4'd5, 32'd1);
    bus_read(4'd5, d, n);
    chk("ien_absent", d, 32'd0);
`endif

    address = 4'd1; writedata = 32'h1234_5678; read = 1'b1; write = 1'b1;
    #1 chk("rw_waitrequest", 32'(waitrequest), 32'd0);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    bus_read(4'd1, d, n);
    chk("rw_write_done", d, 32'h1234_5678);

    // Abort a run inside its first squaring pass.
    bus_write(4'd1, 32'd9);
    bus_write(4'd2, 32'd2);
    bus_write(4'd3, 32'd11);
    bus_write(4'd0, 32'd0);
    bus_read(4'd1, d, n);
    chk("pre_reset_base", d, 32'd9);
    repeat (42) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_waitrequest", 32'(waitrequest), 32'd0);
    chk("midrun_reset_readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      bus_read(4'(a), d, n);
      chk($sformatf("post_reset_reg%0d", a), d, 32'd0);
    end
    run_raw(32'd3, 32'd5, 32'd7, d, bz, st);
    chk("post_reset_result", d, 32'd5);
    chk("post_reset_busy", 32'(bz), 32'(busy_len(32'd5, 32'd7)));
    chk("post_reset_status", st, 32'h2);

    for (int i = 0; i < 8; i++) begin
      b = $urandom;
      e = $urandom >> $urandom_range(0, 31);
      m = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      run_raw(b, e, m, d, bz, st);
      chk($sformatf("rnd%0d_result", i), d, m_pow(b, e, m));
      chk($sformatf("rnd%0d_busy", i), 32'(bz), 32'(busy_len(e, m)));
      chk($sformatf("rnd%0d_status", i), st, (m == 0) ? 32'h6 : 32'h2);
    end

`ifdef EXP_ACCEL_IRQ_EN
    bus_write(4'd5, 32'd1);
    bus_read(4'd5, d, n);
    chk("ien_rw", d, 32'd1);
    bus_write(4'd1, 32'd2);
    bus_write(4'd2, 32'd10);
    bus_write(4'd3, 32'd1000);
    bus_write(4'd0, 32'd0);
    chk("irq_low_while_busy", 32'(irq), 32'd0);
    bus_read(4'd4, d, n);
    chk("irq_result", d, 32'd24);
    chk("irq_high_on_done", 32'(irq), 32'd1);
    bus_write(4'd0, 32'd0);
    chk("irq_cleared_by_start", 32'(irq), 32'd0);
    bus_read(4'd4, d, n);
    chk("irq_high_again", 32'(irq), 32'd1);
    bus_write(4'd5, 32'd0);
    chk("irq_cleared_by_ien0", 32'(irq), 32'd0);
    bus_write(4'd5, 32'd1);
    bus_write(4'd3, 32'd0);
    bus_write(4'd0, 32'd0);
    chk("irq_on_mod0", 32'(irq), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
